// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode, first-word-fall-through.
// Ports: CLK/RST, ihit/imemload/npc in, flush/deq ctrl, accept/valid/instr/npc_out/full/count out.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ihit,
  input  logic [WIDTH-1:0]         imemload,
  input  logic [WIDTH-1:0]         npc,
  input  logic                     flush,
  input  logic                     deq,
  output logic                     accept,
  output logic                     valid,
  output logic [WIDTH-1:0]         instr,
  output logic [WIDTH-1:0]         npc_out,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] npc;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           do_enq;
  logic           do_deq;
  entry_t         head;

  assign count  = cnt;
  assign valid  = (cnt != '0);
  assign full   = (cnt == CW'(DEPTH));
  assign accept = ihit & ~full & ~flush;
  assign do_enq = accept;
  assign do_deq = deq & valid & ~flush;

  assign head    = mem[rd_ptr];
  assign instr   = valid ? head.instr : '0;
  assign npc_out = valid ? head.npc   : '0;

  // Storage needs no reset: valid gates every read.
  always_ff @(posedge CLK) begin
    if (do_enq)
      mem[wr_ptr] <= '{instr: imemload, npc: npc};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_deq)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (do_enq & ~do_deq): cnt <= cnt + 1'b1;
        (do_deq & ~do_enq): cnt <= cnt - 1'b1;
        default:            cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic [31:0] npc = '0;
  logic        flush = 1'b0;
  logic        deq = 1'b0;
  logic        accept;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] npc_out;
  logic        full;
  logic [2:0]  count;

  int tests  = 0;
  int failed = 0;

  logic [63:0] q[$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .npc(npc), .flush(flush), .deq(deq), .accept(accept),
    .valid(valid), .instr(instr), .npc_out(npc_out),
    .full(full), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] ei, en;
    logic        ea;
    ei = (q.size() != 0) ? q[0][63:32] : 32'h0;
    en = (q.size() != 0) ? q[0][31:0]  : 32'h0;
    ea = ihit && (q.size() < DEPTH) && !flush;
    chk({tag, ".count"},  32'(count),  32'(q.size()));
    chk({tag, ".valid"},  32'(valid),  32'(q.size() != 0));
    chk({tag, ".full"},   32'(full),   32'(q.size() == DEPTH));
    chk({tag, ".accept"}, 32'(accept), 32'(ea));
    chk({tag, ".instr"},  instr,       ei);
    chk({tag, ".npc"},    npc_out,     en);
  endtask

  // Drive one cycle, check comb outputs, then advance the model.
  task automatic step(input string tag, input logic i,
                      input logic [31:0] w, input logic [31:0] p,
                      input logic f, input logic d);
    logic acc;
    @(negedge CLK);
    ihit = i; imemload = w; npc = p; flush = f; deq = d;
    #1 chk_model(tag);
    acc = i && (q.size() < DEPTH) && !f;
    @(posedge CLK);
    if (f) q.delete();
    else begin
      if (d && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back({w, p});
    end
  endtask

  task automatic idle(input string tag);
    @(negedge CLK);
    ihit = 0; flush = 0; deq = 0;
    #1 chk_model(tag);
  endtask

  initial begin
    // reset state
    #2 chk_model("reset");
    @(negedge CLK);
    RST = 1'b0;

    // FWFT
    step("fwft0", 1, 32'h8C010004, 32'h4, 0, 0);
    step("fwft1", 1, 32'h00221820, 32'h8, 0, 0);
    idle("fwft2");
    chk("fwft.head", instr, 32'h8C010004);
    chk("fwft.hnpc", npc_out, 32'h4);
    chk("fwft.cnt", 32'(count), 32'd2);
    step("fwft3", 0, 0, 0, 0, 1);
    idle("fwft4");
    chk("fwft.head2", instr, 32'h00221820);
    chk("fwft.hnpc2", npc_out, 32'h8);
    step("drain", 0, 0, 0, 0, 1);

    // Full
    for (int k = 0; k < 4; k++)
      step("fill", 1, 32'hA000_0000 + k, 32'h100 + 4*k, 0, 0);
    idle("full0");
    chk("full.flag", 32'(full), 32'd1);
    chk("full.cnt", 32'(count), 32'd4);
    step("full5", 1, 32'hDEAD_BEEF, 32'h200, 0, 0);
    idle("full6");
    chk("full.head", instr, 32'hA000_0000);
    step("fulldq", 1, 32'hDEAD_BEEF, 32'h200, 0, 1);
    idle("full7");
    chk("full.cnt3", 32'(count), 32'd3);

    // Reset mid-stream at count=3
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.instr", instr, 32'd0);
    q.delete();
    @(negedge CLK);
    RST = 1'b0;

    // Wrap at steady count=2
    step("wp0", 1, 32'h1111_0000, 32'h10, 0, 0);
    step("wp1", 1, 32'h1111_0001, 32'h14, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step("wrap", 1, 32'h2222_0000 + k, 32'h40 + 4*k, 0, 1);
      chk("wrap.le2", 32'(count <= 3'd2), 32'd1);
    end
    step("wd0", 0, 0, 0, 0, 1);

    // enq+deq at count=1
    idle("ed0");
    chk("ed.cnt1", 32'(count), 32'd1);
    step("ed1", 1, 32'h3333_3333, 32'h80, 0, 1);
    idle("ed2");
    chk("ed.cnt", 32'(count), 32'd1);
    chk("ed.head", instr, 32'h3333_3333);

    // Flush at count=3 with ihit and deq
    step("fl0", 1, 32'h4444_0000, 32'h90, 0, 0);
    step("fl1", 1, 32'h4444_0001, 32'h94, 0, 0);
    idle("fl2");
    chk("fl.cnt3", 32'(count), 32'd3);
    @(negedge CLK);
    ihit = 1; imemload = 32'h5555_5555; npc = 32'hA0;
    flush = 1; deq = 1;
    #1 chk("fl.accept", 32'(accept), 32'd0);
    @(posedge CLK);
    q.delete();
    idle("fl3");
    chk("fl.valid", 32'(valid), 32'd0);
    chk("fl.count", 32'(count), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++)
      step("rnd", ($urandom_range(99) < 70), $urandom, $urandom,
           ($urandom_range(99) < 5), ($urandom_range(99) < 55));
    idle("rnd.end");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
